// File: rtl/scene_renderer.sv
// scene_renderer: pixel-colour source for the VGA driver. Composites sky,
// two pipes, ground and an animated bird from a double-buffered scene.
// New scenes are accepted into a shadow buffer and become active only when
// blanking begins, so a frame is never drawn from two different scenes.
module scene_renderer #(
    parameter int          SCR_W       = 640,
    parameter int          SCR_H       = 480,
    parameter int          BIRD_X      = 160,
    parameter int          BIRD_W      = 34,
    parameter int          BIRD_H      = 24,
    parameter int          PIPE_W      = 52,
    parameter int          GAP_H       = 100,
    parameter int          GROUND_Y    = 400,
    parameter int          ANIM_FRAMES = 8,
    parameter logic [11:0] C_SKY       = 12'h4CF,
    parameter logic [11:0] C_PIPE      = 12'h2A2,
    parameter logic [11:0] C_GROUND    = 12'hDB7,
    parameter logic [11:0] C_BIRD_A    = 12'hFD0,
    parameter logic [11:0] C_BIRD_B    = 12'hF80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  curr_x,
    input  logic [9:0]  curr_y,
    input  logic        rdyn,
    input  logic        scn_valid,
    output logic        scn_ready,
    input  logic [9:0]  bird_y,
    input  logic [9:0]  pipe0_x,
    input  logic [9:0]  pipe1_x,
    input  logic [9:0]  pipe0_gap,
    input  logic [9:0]  pipe1_gap,
    output logic [11:0] color,
    output logic        frame_start
);

    localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    typedef struct packed {
        logic [9:0] bird_y;
        logic [9:0] pipe0_x;
        logic [9:0] pipe0_gap;
        logic [9:0] pipe1_x;
        logic [9:0] pipe1_gap;
    } scene_t;

    localparam scene_t SCENE_RST = '{bird_y: 10'd240, pipe0_x: 10'h3FF, pipe0_gap: 10'd0,
                                     pipe1_x: 10'h3FF, pipe1_gap: 10'd0};

    scene_t          shadow_q, shadow_d, active_q, active_d;
    logic            shadow_full_q, shadow_full_d;
    logic            rdyn_dly_q, rdyn_dly_d;
    logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
    logic            wing_q, wing_d;
    logic            frame_start_q, frame_start_d;
    logic            s1_blank_q, s1_blank_d;
    logic            s1_bird_q, s1_bird_d;
    logic            s1_ground_q, s1_ground_d;
    logic            s1_pipe_q, s1_pipe_d;
    logic [11:0]     color_q, color_d;
    logic            blank_edge;

    assign scn_ready   = !shadow_full_q;
    assign color       = color_q;
    assign frame_start = frame_start_q;
    assign blank_edge  = rdyn && !rdyn_dly_q;

    // Pipe hit: inside the column (clipped at the right screen edge) and outside the opening.
    function automatic logic pipe_hit(input logic [10:0] x, input logic [10:0] y,
                                      input logic [9:0] px, input logic [9:0] gap);
        return (x >= {1'b0, px}) && (x < {1'b0, px} + 11'(PIPE_W)) && (x < 11'(SCR_W)) &&
               ((y < {1'b0, gap}) || (y >= {1'b0, gap} + 11'(GAP_H)));
    endfunction

    // Scene handshake, tear-free commit at blank start, wing animation.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        anim_cnt_d    = anim_cnt_q;
        wing_d        = wing_q;
        rdyn_dly_d    = rdyn;
        frame_start_d = blank_edge;
        // Accept and commit are exclusive: accept needs an empty shadow, commit a full one.
        if (scn_valid && !shadow_full_q) begin
            shadow_d      = '{bird_y: bird_y, pipe0_x: pipe0_x, pipe0_gap: pipe0_gap,
                              pipe1_x: pipe1_x, pipe1_gap: pipe1_gap};
            shadow_full_d = 1'b1;
        end
        if (blank_edge) begin
            if (shadow_full_q) begin
                active_d      = shadow_q;
                shadow_full_d = 1'b0;
            end
            if (anim_cnt_q == AW'(ANIM_FRAMES - 1)) begin
                anim_cnt_d = '0;
                wing_d     = !wing_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: hit flags for the presented coordinate against the active scene.
    always_comb begin
        logic [10:0] x11, y11, by11;
        x11  = {1'b0, curr_x};
        y11  = {1'b0, curr_y};
        by11 = {1'b0, active_q.bird_y};
        // Coordinates outside the visible area are treated like blanking.
        s1_blank_d  = rdyn || (x11 >= 11'(SCR_W)) || (y11 >= 11'(SCR_H));
        s1_bird_d   = (x11 >= 11'(BIRD_X)) && (x11 < 11'(BIRD_X + BIRD_W)) &&
                      (y11 >= by11) && (y11 < by11 + 11'(BIRD_H));
        s1_ground_d = (y11 >= 11'(GROUND_Y));
        s1_pipe_d   = pipe_hit(x11, y11, active_q.pipe0_x, active_q.pipe0_gap) ||
                      pipe_hit(x11, y11, active_q.pipe1_x, active_q.pipe1_gap);
    end

    // Stage 2: priority mux blank > bird > ground > pipe > sky.
    always_comb begin
        color_d = C_SKY;
        if (s1_blank_q)       color_d = 12'h000;
        else if (s1_bird_q)   color_d = wing_q ? C_BIRD_B : C_BIRD_A;
        else if (s1_ground_q) color_d = C_GROUND;
        else if (s1_pipe_q)   color_d = C_PIPE;
    end

    // State registers; reset drops any pending scene and flushes the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= SCENE_RST;
            shadow_full_q <= 1'b0;
            active_q      <= SCENE_RST;
            anim_cnt_q    <= '0;
            wing_q        <= 1'b0;
            rdyn_dly_q    <= 1'b1;
            frame_start_q <= 1'b0;
            s1_blank_q    <= 1'b1;
            s1_bird_q     <= 1'b0;
            s1_ground_q   <= 1'b0;
            s1_pipe_q     <= 1'b0;
            color_q       <= 12'h000;
        end else begin
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            anim_cnt_q    <= anim_cnt_d;
            wing_q        <= wing_d;
            rdyn_dly_q    <= rdyn_dly_d;
            frame_start_q <= frame_start_d;
            s1_blank_q    <= s1_blank_d;
            s1_bird_q     <= s1_bird_d;
            s1_ground_q   <= s1_ground_d;
            s1_pipe_q     <= s1_pipe_d;
            color_q       <= color_d;
        end
    end

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: pixel table for one scene plus
// hand-written sequences for handshake, commit timing, animation and reset.
module tb_scene_renderer;

    localparam logic [11:0] SKY = 12'h4CF, PIPE = 12'h2A2, GND = 12'hDB7,
                            BA = 12'hFD0, BB = 12'hF80;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  curr_x, curr_y;
    logic        rdyn;
    logic        scn_valid;
    logic        scn_ready;
    logic [9:0]  bird_y, pipe0_x, pipe1_x, pipe0_gap, pipe1_gap;
    logic [11:0] color;
    logic        frame_start;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[18];

    scene_renderer dut (
        .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y), .rdyn(rdyn),
        .scn_valid(scn_valid), .scn_ready(scn_ready), .bird_y(bird_y),
        .pipe0_x(pipe0_x), .pipe1_x(pipe1_x), .pipe0_gap(pipe0_gap), .pipe1_gap(pipe1_gap),
        .color(color), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_scene(input logic [9:0] by, input logic [9:0] p0, input logic [9:0] g0,
                             input logic [9:0] p1, input logic [9:0] g1);
        bird_y = by; pipe0_x = p0; pipe0_gap = g0; pipe1_x = p1; pipe1_gap = g1;
    endtask

    // Present a visible coordinate and check the colour two clocks later.
    task automatic pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] exp);
        curr_x = x; curr_y = y; rdyn = 1'b0;
        tick();
        tick();
        chk(nm, color, exp);
    endtask

    // One visible->blank transition, back to visible afterwards.
    task automatic do_edge(input string nm);
        rdyn = 1'b1;
        tick();
        chk({nm, "_fs1"}, {11'd0, frame_start}, 12'd1);
        rdyn = 1'b0;
        tick();
        chk({nm, "_fs0"}, {11'd0, frame_start}, 12'd0);
    endtask

    initial begin
        tbl[0]  = '{10'd170, 10'd110, BA};
        tbl[1]  = '{10'd310, 10'd50,  PIPE};
        tbl[2]  = '{10'd310, 10'd200, SKY};
        tbl[3]  = '{10'd310, 10'd420, GND};
        tbl[4]  = '{10'd320, 10'd300, PIPE};
        tbl[5]  = '{10'd160, 10'd100, BA};
        tbl[6]  = '{10'd193, 10'd123, BA};
        tbl[7]  = '{10'd194, 10'd110, SKY};
        tbl[8]  = '{10'd159, 10'd110, SKY};
        tbl[9]  = '{10'd170, 10'd124, SKY};
        tbl[10] = '{10'd300, 10'd149, PIPE};
        tbl[11] = '{10'd351, 10'd149, PIPE};
        tbl[12] = '{10'd352, 10'd149, SKY};
        tbl[13] = '{10'd299, 10'd149, SKY};
        tbl[14] = '{10'd310, 10'd150, SKY};
        tbl[15] = '{10'd310, 10'd249, SKY};
        tbl[16] = '{10'd310, 10'd250, PIPE};
        tbl[17] = '{10'd310, 10'd400, GND};

        rst = 1'b1; rdyn = 1'b0; curr_x = '0; curr_y = '0; scn_valid = 1'b0;
        set_scene(10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        repeat (3) tick();
        chk("rst_color", color, 12'h000);
        chk("rst_ready", {11'd0, scn_ready}, 12'd1);
        chk("rst_fs", {11'd0, frame_start}, 12'd0);
        rst = 1'b0;
        tick();
        chk("rel_lat1", color, 12'h000);
        tick();
        chk("rel_sky", color, SKY);

        // Scene A, commit on first edge (edge 1)
        set_scene(10'd100, 10'd300, 10'd150, 10'h3FF, 10'd0);
        scn_valid = 1'b1;
        tick();
        chk("a_held", {11'd0, scn_ready}, 12'd0);
        scn_valid = 1'b0;
        rdyn = 1'b1;
        tick();
        chk("a_fs", {11'd0, frame_start}, 12'd1);
        chk("a_ready", {11'd0, scn_ready}, 12'd1);
        rdyn = 1'b0;
        tick();
        chk("a_fs_off", {11'd0, frame_start}, 12'd0);
        for (int i = 0; i < 18; i++)
            pix($sformatf("tblA[%0d]", i), tbl[i].x, tbl[i].y, tbl[i].exp);

        // Latency: sky -> bird takes exactly two clocks
        pix("lat_pre", 10'd310, 10'd200, SKY);
        curr_x = 10'd170; curr_y = 10'd110;
        tick();
        chk("lat_1", color, SKY);
        tick();
        chk("lat_2", color, BA);

        // Back-to-back scenes B then C; C waits for the second edge
        set_scene(10'd200, 10'h3FF, 10'd0, 10'd620, 10'd0);
        scn_valid = 1'b1;
        tick();
        chk("b_held", {11'd0, scn_ready}, 12'd0);
        set_scene(10'd300, 10'd620, 10'd0, 10'h3FF, 10'd0);
        tick();
        chk("c_blocked", {11'd0, scn_ready}, 12'd0);
        pix("no_commit", 10'd170, 10'd110, BA);
        rdyn = 1'b1;                                 // edge 2 commits B
        tick();
        chk("b_fs", {11'd0, frame_start}, 12'd1);
        chk("b_ready", {11'd0, scn_ready}, 12'd1);
        rdyn = 1'b0;
        tick();                                      // C accepted here
        chk("c_held", {11'd0, scn_ready}, 12'd0);
        scn_valid = 1'b0;
        pix("b_bird", 10'd170, 10'd210, BA);
        pix("b_p1_620", 10'd620, 10'd300, PIPE);
        pix("b_p1_639", 10'd639, 10'd300, PIPE);
        pix("b_p1_619", 10'd619, 10'd300, SKY);
        pix("b_p1_gap", 10'd630, 10'd50, SKY);
        pix("b_old_a", 10'd170, 10'd110, SKY);
        do_edge("c_edge");                           // edge 3 commits C
        chk("c_ready", {11'd0, scn_ready}, 12'd1);
        pix("c_old_b", 10'd170, 10'd210, SKY);
        pix("c_bird", 10'd170, 10'd310, BA);
        pix("c_p0_639", 10'd639, 10'd200, PIPE);
        pix("c_p0_619", 10'd619, 10'd200, SKY);
        pix("c_p1_none", 10'd5, 10'd200, SKY);

        // Wing animation: toggles on edge 8 and again on edge 16
        for (int i = 4; i <= 7; i++) do_edge($sformatf("e%0d", i));
        pix("wing_e7", 10'd170, 10'd310, BA);
        do_edge("e8");
        pix("wing_e8", 10'd170, 10'd310, BB);
        for (int i = 9; i <= 15; i++) do_edge($sformatf("e%0d", i));
        pix("wing_e15", 10'd170, 10'd310, BB);
        do_edge("e16");
        pix("wing_e16", 10'd170, 10'd310, BA);

        // Blanking over the bird: black exactly two clocks later (edge 17)
        pix("blk_pre", 10'd170, 10'd310, BA);
        rdyn = 1'b1;
        tick();
        chk("blk_1", color, BA);
        tick();
        chk("blk_2", color, 12'h000);
        rdyn = 1'b0;
        tick();

        // Reset with a pending shadow scene mid-line
        set_scene(10'd50, 10'h3FF, 10'd0, 10'h3FF, 10'd0);
        scn_valid = 1'b1;
        tick();
        chk("d_held", {11'd0, scn_ready}, 12'd0);
        scn_valid = 1'b0;
        pix("d_pre", 10'd170, 10'd310, BA);
        rst = 1'b1;
        tick();
        chk("mrst_ready", {11'd0, scn_ready}, 12'd1);
        chk("mrst_color", color, 12'h000);
        rst = 1'b0;
        tick();
        do_edge("mrst_edge");
        chk("mrst_ready2", {11'd0, scn_ready}, 12'd1);
        pix("mrst_bird", 10'd170, 10'd250, BA);
        pix("mrst_no_d", 10'd170, 10'd60, SKY);
        pix("mrst_nopipe", 10'd0, 10'd300, SKY);

        // Scene accepted in the edge cycle waits for the following edge
        set_scene(10'd350, 10'h3FF, 10'd0, 10'h3FF, 10'd0);
        scn_valid = 1'b1;
        rdyn = 1'b1;
        tick();
        chk("e_fs", {11'd0, frame_start}, 12'd1);
        chk("e_held", {11'd0, scn_ready}, 12'd0);
        scn_valid = 1'b0;
        rdyn = 1'b0;
        tick();
        pix("e_wait", 10'd170, 10'd360, SKY);
        pix("e_old", 10'd170, 10'd250, BA);
        do_edge("e_commit");
        chk("e_ready", {11'd0, scn_ready}, 12'd1);
        pix("e_new", 10'd170, 10'd360, BA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
